// File: rtl/vivo_fifo_pkg.sv
// Shared widths, helpers and state typedefs for the multi-element FIFO.
package vivo_fifo_pkg;

    // Internal pointer/count width; supports DEPTH up to 32767 so that
    // pointer + offset never overflows before the modulo fold.
    localparam int CNT_W = 16;
    // Internal element-count width for per-beat quantities.
    localparam int NUM_W = 8;

    // Bits needed to hold the values 0..n.
    function automatic int num_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to address n slots (at least one bit).
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // (base + step) mod depth, valid when base < depth and step <= depth.
    function automatic logic [CNT_W-1:0] wrap_add(
        input logic [CNT_W-1:0] base,
        input logic [CNT_W-1:0] step,
        input logic [CNT_W-1:0] depth
    );
        logic [CNT_W-1:0] sum;
        sum = base + step;
        return (sum >= depth) ? sum - depth : sum;
    endfunction

    // Ring pointers and stored-element count.
    typedef struct packed {
        logic [CNT_W-1:0] wr_ptr;
        logic [CNT_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;
    } ptr_cnt_t;

    // Output register control fields (data is held alongside).
    typedef struct packed {
        logic             valid;
        logic [NUM_W-1:0] num;
    } out_stage_t;

endpackage

// File: rtl/vivo_ring_mem.sv
// DEPTH-entry ring buffer with a multi-element write window and a
// combinational multi-element read window, both modulo DEPTH.
module vivo_ring_mem
    import vivo_fifo_pkg::*;
#(
    parameter int ELEM_WIDTH    = 8,
    parameter int DEPTH         = 64,
    parameter int IN_ELEMS_MAX  = 4,
    parameter int OUT_ELEMS_MAX = 4
) (
    input  logic                                     clk,
    input  logic                                     wr_en,
    input  logic [CNT_W-1:0]                         wr_ptr,
    input  logic [NUM_W-1:0]                         wr_num,
    input  logic [IN_ELEMS_MAX-1:0][ELEM_WIDTH-1:0]  wr_data,
    input  logic [CNT_W-1:0]                         rd_ptr,
    output logic [OUT_ELEMS_MAX-1:0][ELEM_WIDTH-1:0] rd_data
);

    localparam int              AW      = addr_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ELEM_WIDTH-1:0]             ring [DEPTH];
    logic [IN_ELEMS_MAX-1:0][AW-1:0]   wr_addr;
    logic [IN_ELEMS_MAX-1:0]           wr_lane;

    genvar gi;
    generate
        for (gi = 0; gi < IN_ELEMS_MAX; gi++) begin : g_wr
            assign wr_addr[gi] = AW'(wrap_add(wr_ptr, CNT_W'(gi), DEPTH_C));
            assign wr_lane[gi] = wr_en && (NUM_W'(gi) < wr_num);
        end
        for (gi = 0; gi < OUT_ELEMS_MAX; gi++) begin : g_rd
            assign rd_data[gi] = ring[AW'(wrap_add(rd_ptr, CNT_W'(gi), DEPTH_C))];
        end
    endgenerate

    // Write the first wr_num lanes into consecutive ring slots.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_ELEMS_MAX; i++) begin
            if (wr_lane[i]) begin
                ring[wr_addr[i]] <= wr_data[i];
            end
        end
    end

endmodule

// File: rtl/vivo_fifo_v2.sv
// Multi-element-per-beat FIFO: variable-size push and pop beats, registered
// output stage, level/threshold status and a sticky illegal-request flag.
module vivo_fifo_v2
    import vivo_fifo_pkg::*;
#(
    parameter int ELEM_WIDTH     = 8,
    parameter int DEPTH          = 64,
    parameter int IN_ELEMS_MAX   = 4,
    parameter int OUT_ELEMS_MAX  = 4,
    parameter int PARTIAL_POP_EN = 0,
    parameter int AF_THRESH      = DEPTH - IN_ELEMS_MAX,
    parameter int AE_THRESH      = OUT_ELEMS_MAX,
    localparam int IN_W          = num_width(IN_ELEMS_MAX),
    localparam int OUT_W         = num_width(OUT_ELEMS_MAX),
    localparam int LVL_W         = num_width(DEPTH)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [IN_ELEMS_MAX-1:0][ELEM_WIDTH-1:0]  in_data,
    input  logic [IN_W-1:0]                          in_num_elems,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [OUT_ELEMS_MAX-1:0][ELEM_WIDTH-1:0] out_data,
    output logic [OUT_W-1:0]                         out_num_elems,
    input  logic [OUT_W-1:0]                         out_req_elems,
    input  logic                                     flush,
    output logic [LVL_W-1:0]                         level,
    output logic                                     almost_full,
    output logic                                     almost_empty,
    output logic                                     err
);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C      = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C      = CNT_W'(AE_THRESH);
    localparam logic [NUM_W-1:0] IN_MAX_N  = NUM_W'(IN_ELEMS_MAX);
    localparam logic [NUM_W-1:0] OUT_MAX_N = NUM_W'(OUT_ELEMS_MAX);

    ptr_cnt_t                                st_reg, st_next;
    out_stage_t                              os_reg, os_next;
    logic [OUT_ELEMS_MAX-1:0][ELEM_WIDTH-1:0] out_data_reg, out_data_next;
    logic                                    err_reg, err_next;

    logic [NUM_W-1:0]                        in_n, req_n, popped, grant;
    logic                                    push, pop, req_bad, in_bad;
    logic [CNT_W-1:0]                        free_slots, avail, rd_ptr_pop;
    logic [OUT_ELEMS_MAX-1:0][ELEM_WIDTH-1:0] rd_window;

    assign in_n   = NUM_W'(in_num_elems);
    assign req_n  = NUM_W'(out_req_elems);

    // Acceptance looks only at the registered count, so a same-cycle pop
    // never frees room for a same-cycle push.
    assign free_slots = DEPTH_C - st_reg.count;
    assign in_ready   = !flush && (in_n != '0) && (in_n <= IN_MAX_N)
                        && (CNT_W'(in_n) <= free_slots);
    assign push       = in_valid && in_ready;

    // A pop always retires what the output register holds, not the live request.
    assign pop        = os_reg.valid && out_ready;
    assign popped     = pop ? os_reg.num : '0;
    assign avail      = st_reg.count - CNT_W'(popped);
    assign rd_ptr_pop = wrap_add(st_reg.rd_ptr, CNT_W'(popped), DEPTH_C);

    assign req_bad = req_n > OUT_MAX_N;
    assign in_bad  = in_valid && (in_n > IN_MAX_N);

    vivo_ring_mem #(
        .ELEM_WIDTH    (ELEM_WIDTH),
        .DEPTH         (DEPTH),
        .IN_ELEMS_MAX  (IN_ELEMS_MAX),
        .OUT_ELEMS_MAX (OUT_ELEMS_MAX)
    ) u_ring (
        .clk     (clk),
        .wr_en   (push),
        .wr_ptr  (st_reg.wr_ptr),
        .wr_num  (in_n),
        .wr_data (in_data),
        .rd_ptr  (rd_ptr_pop),
        .rd_data (rd_window)
    );

    // Grant size: the full request if available, else optionally what is there.
    always_comb begin
        grant = '0;
        if (!req_bad && (req_n != '0)) begin
            if (CNT_W'(req_n) <= avail) begin
                grant = req_n;
            end else if ((PARTIAL_POP_EN != 0) && (avail != '0)) begin
                grant = NUM_W'(avail);
            end
        end
    end

    // Next-state for pointers, count, output stage and error flag.
    always_comb begin
        st_next       = st_reg;
        os_next       = os_reg;
        out_data_next = out_data_reg;
        err_next      = err_reg;
        if (flush) begin
            st_next       = '0;
            os_next       = '0;
            out_data_next = '0;
            err_next      = 1'b0;
        end else begin
            st_next.count  = st_reg.count + (push ? CNT_W'(in_n) : '0) - CNT_W'(popped);
            st_next.rd_ptr = rd_ptr_pop;
            if (push) begin
                st_next.wr_ptr = wrap_add(st_reg.wr_ptr, CNT_W'(in_n), DEPTH_C);
            end
            if ((!os_reg.valid || pop) && (grant != '0)) begin
                os_next.valid = 1'b1;
                os_next.num   = grant;
                for (int i = 0; i < OUT_ELEMS_MAX; i++) begin
                    out_data_next[i] = (NUM_W'(i) < grant) ? rd_window[i] : '0;
                end
            end else if (pop) begin
                os_next       = '0;
                out_data_next = '0;
            end
            err_next = err_reg || in_bad || req_bad;
        end
    end

    // State registers with immediate clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_reg       <= '0;
            os_reg       <= '0;
            out_data_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            st_reg       <= st_next;
            os_reg       <= os_next;
            out_data_reg <= out_data_next;
            err_reg      <= err_next;
        end
    end

    assign out_valid     = os_reg.valid;
    assign out_num_elems = OUT_W'(os_reg.num);
    assign out_data      = out_data_reg;
    assign level         = LVL_W'(st_reg.count);
    assign almost_full   = st_reg.count >= AF_C;
    assign almost_empty  = st_reg.count <= AE_C;
    assign err           = err_reg;

endmodule

// File: tb/tb_vivo_fifo_v2.sv
// Directed bench for vivo_fifo_v2 at DEPTH=10, 4-element beats, with a
// second instance built with partial pops enabled sharing the same inputs.
module tb_vivo_fifo_v2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [3:0][7:0] in_data;
    logic [2:0]      in_num_elems;
    logic            out_ready;
    logic [2:0]      out_req_elems;
    logic            flush;

    logic            in_ready, out_valid, almost_full, almost_empty, err;
    logic [3:0][7:0] out_data;
    logic [2:0]      out_num_elems;
    logic [3:0]      level;

    logic            in_ready_p, out_valid_p, almost_full_p, almost_empty_p, err_p;
    logic [3:0][7:0] out_data_p;
    logic [2:0]      out_num_elems_p;
    logic [3:0]      level_p;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vivo_fifo_v2 #(.ELEM_WIDTH(8), .DEPTH(10), .IN_ELEMS_MAX(4), .OUT_ELEMS_MAX(4),
                   .PARTIAL_POP_EN(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_num_elems(in_num_elems), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_num_elems(out_num_elems),
        .out_req_elems(out_req_elems), .flush(flush), .level(level),
        .almost_full(almost_full), .almost_empty(almost_empty), .err(err)
    );

    vivo_fifo_v2 #(.ELEM_WIDTH(8), .DEPTH(10), .IN_ELEMS_MAX(4), .OUT_ELEMS_MAX(4),
                   .PARTIAL_POP_EN(1)) dut_p (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_p),
        .in_data(in_data), .in_num_elems(in_num_elems), .out_valid(out_valid_p),
        .out_ready(out_ready), .out_data(out_data_p), .out_num_elems(out_num_elems_p),
        .out_req_elems(out_req_elems), .flush(flush), .level(level_p),
        .almost_full(almost_full_p), .almost_empty(almost_empty_p), .err(err_p)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_in(input int n, input int base);
        in_num_elems = 3'(n);
        for (int i = 0; i < 4; i++) begin
            in_data[i] = (i < n) ? 8'(base + i) : 8'h00;
        end
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
    endtask

    int q[$];
    int pushed, cyc, n, exp_v;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_num_elems = 3'd1;
        out_ready = 1'b0; out_req_elems = 3'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", level, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_p_level", level_p, 0);
        check("rst_p_ae", almost_empty_p, 1);
        check("rst_p_af", almost_full_p, 0);
        check("rst_p_err", err_p, 0);
        check("rst_p_ready", in_ready_p, 1);
        rst = 1'b0;

        // Push {A,B,C}, request 2 with ready low, hold.
        in_valid = 1'b1; load_in(3, 8'hA0); out_req_elems = 3'd2; out_ready = 1'b0;
        #1 check("t1_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t1_level", level, 3);
        check("t1_valid_t0", out_valid, 0);
        tick();
        check("t1_valid_t1", out_valid, 1);
        check("t1_num", out_num_elems, 2);
        check("t1_d0", out_data[0], 8'hA0);
        check("t1_d1", out_data[1], 8'hA1);
        check("t1_d2", out_data[2], 0);
        check("t1_d3", out_data[3], 0);
        out_req_elems = 3'd4;
        tick();
        check("t1_hold_num", out_num_elems, 2);
        check("t1_hold_d0", out_data[0], 8'hA0);
        check("t1_hold_level", level, 3);
        out_req_elems = 3'd2; out_ready = 1'b1;
        tick();
        check("t1_fall_valid", out_valid, 0);
        check("t1_fall_num", out_num_elems, 0);
        check("t1_fall_level", level, 1);
        out_ready = 1'b0;
        do_flush();

        // Eight stored, steady 2-element pops.
        out_req_elems = 3'd0;
        in_valid = 1'b1; load_in(4, 10); tick();
        load_in(4, 14); tick();
        in_valid = 1'b0;
        check("t2_level", level, 8);
        check("t2_af", almost_full, 1);
        check("t2_ae", almost_empty, 0);
        check("t2_valid_idle", out_valid, 0);
        out_req_elems = 3'd2; out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            tick();
            check("t2_valid", out_valid, 1);
            check("t2_d0", out_data[0], 10 + 2 * b);
            check("t2_d1", out_data[1], 11 + 2 * b);
            check("t2_level_beat", level, 8 - 2 * b);
        end
        tick();
        check("t2_end_valid", out_valid, 0);
        check("t2_end_level", level, 0);
        out_ready = 1'b0; out_req_elems = 3'd0;
        do_flush();

        // Request exceeding stored count: strict vs partial.
        in_valid = 1'b1; load_in(3, 30); out_req_elems = 3'd4; tick();
        in_valid = 1'b0;
        tick();
        check("t3_level", level, 3);
        check("t3_ae", almost_empty, 1);
        check("t3_strict_valid", out_valid, 0);
        check("t3_part_valid", out_valid_p, 1);
        check("t3_part_num", out_num_elems_p, 3);
        check("t3_part_d0", out_data_p[0], 30);
        check("t3_part_d3", out_data_p[3], 0);
        check("t3_part_level", level_p, 3);
        tick();
        check("t3_strict_still", out_valid, 0);
        out_req_elems = 3'd0;
        do_flush();

        // Full FIFO: pop with simultaneous push is refused that cycle.
        in_valid = 1'b1; load_in(4, 40); tick();
        load_in(4, 44); tick();
        load_in(2, 48); tick();
        check("t4_level_full", level, 10);
        check("t4_af", almost_full, 1);
        load_in(1, 0);
        #1 check("t4_full_ready", in_ready, 0);
        in_valid = 1'b0; out_req_elems = 3'd4;
        tick();
        check("t4_load_num", out_num_elems, 4);
        check("t4_load_d0", out_data[0], 40);
        out_ready = 1'b1; in_valid = 1'b1; load_in(4, 50);
        #1 check("t4_pop_ready", in_ready, 0);
        tick();
        out_ready = 1'b0;
        check("t4_after_pop_level", level, 6);
        check("t4_next_d0", out_data[0], 44);
        #1 check("t4_retry_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t4_refill_level", level, 10);
        out_req_elems = 3'd0;
        do_flush();

        // Random sizes through several wraps; scoreboard checks order.
        q.delete(); pushed = 0; cyc = 0;
        while ((pushed < 100 || q.size() != 0 || out_valid) && cyc < 3000) begin
            n = $urandom_range(1, 4);
            if (pushed + n > 100) n = 100 - pushed;
            if (n == 0) n = 1;
            in_valid = (pushed < 100) && ($urandom_range(0, 3) != 0);
            load_in(n, pushed);
            out_req_elems = 3'($urandom_range(1, 4));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                for (int i = 0; i < int'(out_num_elems); i++) begin
                    exp_v = (q.size() > 0) ? q.pop_front() : -1;
                    check("rnd_data", out_data[i], exp_v);
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < n; i++) q.push_back((pushed + i) & 8'hFF);
                pushed += n;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0; out_req_elems = 3'd0;
        check("rnd_in_time", (cyc < 3000) ? 1 : 0, 1);
        check("rnd_pushed", pushed, 100);
        check("rnd_level", level, 0);
        check("rnd_err", err, 0);

        // Illegal requests set err; flush clears everything.
        in_valid = 1'b1; load_in(4, 60); out_req_elems = 3'd2; tick();
        in_valid = 1'b0; tick();
        check("t6_valid", out_valid, 1);
        in_valid = 1'b1; load_in(5, 0);
        #1 check("t6_bad_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        check("t6_err", err, 1);
        check("t6_level", level, 4);
        check("t6_hold_valid", out_valid, 1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("t6_fl_valid", out_valid, 0);
        check("t6_fl_level", level, 0);
        check("t6_fl_err", err, 0);
        check("t6_fl_ae", almost_empty, 1);
        out_req_elems = 3'd6; tick();
        check("t6_req_err", err, 1);
        check("t6_req_valid", out_valid, 0);
        out_req_elems = 3'd0;
        do_flush();
        check("t6_req_err_clr", err, 0);

        // Asynchronous reset mid-transfer, then first push after release.
        in_valid = 1'b1; load_in(4, 70); out_req_elems = 3'd2; tick();
        in_valid = 1'b0; tick();
        check("t7_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_level", level, 0);
        check("t7_rst_valid", out_valid, 0);
        check("t7_rst_num", out_num_elems, 0);
        check("t7_rst_d0", out_data[0], 0);
        check("t7_rst_ae", almost_empty, 1);
        out_req_elems = 3'd0;
        tick();
        rst = 1'b0; in_valid = 1'b1; load_in(2, 80);
        tick();
        in_valid = 1'b0;
        check("t7_first_push", level, 2);
        out_req_elems = 3'd2;
        tick();
        check("t7_out_valid", out_valid, 1);
        check("t7_out_d0", out_data[0], 80);
        check("t7_out_d1", out_data[1], 81);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vivo_fifo_v2.md
VIVO_FIFO_V2 -- requirements
Module: vivo_fifo_v2

Interface
REQ-001 ELEM_WIDTH, 8, bits per element.
REQ-002 DEPTH, 64, total element capacity; any integer >= max(IN_ELEMS_MAX, OUT_ELEMS_MAX); need not be a power of two.
REQ-003 IN_ELEMS_MAX, 4, max elements per push beat.
REQ-004 OUT_ELEMS_MAX, 4, max elements per pop beat.
REQ-005 PARTIAL_POP_EN, 0, 1 = grant min(req, available) instead of waiting for the full request.
REQ-006 AF_THRESH, DEPTH-IN_ELEMS_MAX, almost_full level; AE_THRESH, OUT_ELEMS_MAX, almost_empty level.
REQ-007 clk  in  1  single clock, rising edge; all state is on this clock.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 in_valid  in  1; in_ready  out  1; in_data  in  IN_ELEMS_MAX x ELEM_WIDTH, element 0 oldest; in_num_elems  in  clog2(IN_ELEMS_MAX+1).
REQ-010 out_valid  out  1; out_ready  in  1; out_data  out  OUT_ELEMS_MAX x ELEM_WIDTH; out_num_elems  out  clog2(OUT_ELEMS_MAX+1); out_req_elems  in  clog2(OUT_ELEMS_MAX+1).
REQ-011 flush  in  1, synchronous clear; level  out  clog2(DEPTH+1), stored count; almost_full  out  1; almost_empty  out  1; err  out  1, sticky illegal-request flag.

Function
REQ-012 count includes elements held in the output register until their pop handshake; level = count.
REQ-013 in_ready = !flush && 0 < in_num_elems <= IN_ELEMS_MAX && in_num_elems <= DEPTH - count, using registered count only; push fires on in_valid && in_ready.
REQ-014 A push writes in_data[0..n-1] to consecutive ring slots from wr_ptr; wr_ptr advances by n modulo DEPTH.
REQ-015 Pop fires on out_valid && out_ready; it removes exactly the registered out_num_elems, not the current out_req_elems.
REQ-016 avail = count - (pop fires ? out_num_elems : 0); pushed data becomes visible to the output stage one cycle after the push edge.
REQ-017 The output register loads when (out_valid == 0 or pop fires) and grant > 0.
REQ-018 grant = out_req_elems if 1 <= out_req_elems <= avail; else, when PARTIAL_POP_EN = 1 and avail > 0, grant = min(out_req_elems, avail); else grant = 0.
REQ-019 Loaded out_data[i] = ring[(rd_ptr' + i) mod DEPTH] for i < grant and 0 above; rd_ptr' is rd_ptr advanced by any pop firing that cycle.
REQ-020 Back-to-back pops are sustained at one beat per cycle with no bubble.
REQ-021 While out_valid = 1 and out_ready = 0, out_data and out_num_elems are held stable and changes on out_req_elems are ignored.
REQ-022 If a pop fires and grant = 0, out_valid falls next cycle; out_num_elems = 0 whenever out_valid = 0.
REQ-023 Simultaneous push and pop: next count = count + pushed - popped; at full, a pop does not raise in_ready in the same cycle.
REQ-024 almost_full = (count >= AF_THRESH); almost_empty = (count <= AE_THRESH); both decoded from registered count.
REQ-025 err sets when in_valid is high with in_num_elems > IN_ELEMS_MAX, or out_req_elems > OUT_ELEMS_MAX; it stays set until flush or reset.
REQ-026 An out_req_elems value that sets err yields grant = 0.
REQ-027 flush: next cycle count, rd_ptr, wr_ptr, out_valid and err = 0; a push or pop in the flush cycle is discarded.

Reset
REQ-028 rst asserted: immediately clears count, rd_ptr, wr_ptr, out_valid, out_num_elems, out_data and err; level = 0, almost_empty = 1, almost_full = 0.
REQ-029 Ring storage contents are not reset; reset mid-transfer discards all held data.
REQ-030 Release of rst is synchronous to clk; the first push is accepted on the first edge after release.

Structure
REQ-031 Package vivo_fifo_pkg holds the width-function helpers, the pointer/count struct typedef and the output-stage struct typedef.
REQ-032 Sub-module vivo_ring_mem: DEPTH x ELEM_WIDTH ring with an IN_ELEMS_MAX-wide write window and an OUT_ELEMS_MAX-wide combinational read window, modulo-DEPTH addressing.
REQ-033 vivo_fifo_v2 owns control, counting, status and the output register.

Verification (DEPTH=10, IN=OUT=4 unless stated)
REQ-034 Push {A,B,C} at edge T0, req=2, ready=0 -> level=3 after T0; out_valid=1 after T1 with out_data={A,B,0,0}, num=2; outputs held while ready=0.
REQ-035 8 elements stored, req=2, ready=1 constant -> 4 consecutive beats {e0,e1}..{e6,e7}, level 8,6,4,2,0, then out_valid=0.
REQ-036 level=3, req=4 -> PARTIAL_POP_EN=0: out_valid stays 0; PARTIAL_POP_EN=1: out_num_elems=3.
REQ-037 Fill to 10 -> in_ready=0 for num=1; pop 4 with push num=4 in the same cycle -> push refused, accepted next cycle, level returns to 10.
REQ-038 Random push/pop sizes over 100 elements (several wraps of non-power-of-2 DEPTH) -> output order exactly equals input order.
REQ-039 out_valid held, in_num_elems=5 injected (err=1), then flush -> next cycle out_valid=0, level=0, err=0, almost_empty=1.
